// File: rtl/iob_2p_mem_tiled_clr.sv
// Two-port (1W/1R) word memory split into tiles, with byte write strobes,
// optional output register, and a hardware clear that zeroes every tile
// in parallel, one offset per cycle.
module iob_2p_mem_tiled_clr #(
    parameter int DATA_W     = 16,
    parameter int N_WORDS    = 8192,
    parameter int TILE_WORDS = 2048,
    parameter int OUT_REG    = 0,
    localparam int ADDR_W    = $clog2(N_WORDS),
    localparam int N_TILES   = N_WORDS / TILE_WORDS,
    localparam int STRB_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    input  logic              w_en,
    input  logic [STRB_W-1:0] w_strb,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] data_out,
    output logic              r_valid
);
    localparam int OFF_W = $clog2(TILE_WORDS);
    localparam int TIL_W = (N_TILES > 1) ? $clog2(N_TILES) : 1;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_CLEAR = 1'b1;

    logic              r_state;
    logic [OFF_W-1:0]  r_off;
    logic              r_v1;
    logic [TIL_W-1:0]  r_rtile;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_clr_wr;
    logic [TIL_W-1:0]  w_wtile;
    logic [TIL_W-1:0]  w_rtile;
    logic [OFF_W-1:0]  w_woff;
    logic [OFF_W-1:0]  w_roff;
    logic [DATA_W-1:0] w_tq [N_TILES];
    logic [DATA_W-1:0] w_rdata;

    assign busy = (r_state == S_CLEAR);

    // clr wins over a same-cycle access; rst wins over everything,
    // including the clear write of the cycle it lands in
    assign w_wr_acc = w_en && !busy && !clr && !rst;
    assign w_rd_acc = r_en && !busy && !clr && !rst;
    assign w_clr_wr = busy && !rst;

    assign w_wtile = TIL_W'(w_addr >> OFF_W);
    assign w_rtile = TIL_W'(r_addr >> OFF_W);
    assign w_woff  = w_addr[OFF_W-1:0];
    assign w_roff  = r_addr[OFF_W-1:0];

    // clear sequencer: one offset per cycle, leaves on the last offset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_off   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_off <= '0;
                    if (clr) r_state <= S_CLEAR;
                end
                default: begin
                    if (r_off == OFF_W'(TILE_WORDS - 1)) begin
                        r_state <= S_IDLE;
                        r_off   <= '0;
                    end else begin
                        r_off <= r_off + 1'b1;
                    end
                end
            endcase
        end
    end

    // per-tile storage; only the addressed tile sees an access
    for (genvar t = 0; t < N_TILES; t++) begin : g_tile
        logic [DATA_W-1:0] r_mem [TILE_WORDS];
        logic [DATA_W-1:0] r_q;

        // write port: clear has the port while busy, else strobed user write
        always_ff @(posedge clk) begin
            if (w_clr_wr) begin
                r_mem[r_off] <= '0;
            end else if (w_wr_acc && (w_wtile == TIL_W'(t))) begin
                for (int b = 0; b < STRB_W; b++)
                    if (w_strb[b]) r_mem[w_woff][8*b +: 8] <= data_in[8*b +: 8];
            end
        end

        // read port: old data is returned on a same-address write
        always_ff @(posedge clk) begin
            if (w_rd_acc && (w_rtile == TIL_W'(t))) r_q <= r_mem[w_roff];
        end

        assign w_tq[t] = r_q;
    end

    assign w_rdata = w_tq[r_rtile];

    // first read stage: valid flag and which tile to pick the word from
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_rtile <= '0;
        end else begin
            r_v1 <= w_rd_acc;
            if (w_rd_acc) r_rtile <= w_rtile;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic              r_v2;
        logic [DATA_W-1:0] r_dout;

        // extra output stage; drains even while a clear runs
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v2   <= 1'b0;
                r_dout <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) r_dout <= w_rdata;
            end
        end

        assign data_out = r_dout;
        assign r_valid  = r_v2;
    end else begin : g_nreg
        logic [DATA_W-1:0] r_hold;

        // remembers the last presented word so data_out holds between reads
        always_ff @(posedge clk) begin
            if (rst)       r_hold <= '0;
            else if (r_v1) r_hold <= w_rdata;
        end

        assign data_out = r_v1 ? w_rdata : r_hold;
        assign r_valid  = r_v1;
    end

endmodule

// File: tb/tb_iob_2p_mem_tiled_clr.sv
// Bench: two instances (OUT_REG=0 and OUT_REG=1) driven with the same
// directed stimulus, checked every cycle against a word-array model, plus
// literal expectations at the interesting points.
module tb_iob_2p_mem_tiled_clr;
    localparam int TW = 2048;

    logic        clk = 1'b0;
    logic        rst, clr, w_en, r_en;
    logic [1:0]  w_strb;
    logic [12:0] w_addr, r_addr;
    logic [15:0] data_in;
    logic        busy0, busy1, r_valid0, r_valid1;
    logic [15:0] data_out0, data_out1;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    iob_2p_mem_tiled_clr #(.OUT_REG(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy0),
        .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr), .data_in(data_in),
        .r_en(r_en), .r_addr(r_addr), .data_out(data_out0), .r_valid(r_valid0));

    iob_2p_mem_tiled_clr #(.OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy1),
        .w_en(w_en), .w_strb(w_strb), .w_addr(w_addr), .data_in(data_in),
        .r_en(r_en), .r_addr(r_addr), .data_out(data_out1), .r_valid(r_valid1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [15:0] mm [8192];
    int          cnt = 0, off = 0, cycn = 0;
    logic [15:0] qd0[$], qd1[$];
    int          qt0[$], qt1[$];
    logic        ev0 = 0, ev1 = 0;
    logic [15:0] ed0 = 0, ed1 = 0;

    initial forever begin
        @(posedge clk);
        cycn++;
        if (rst) begin
            cnt = 0; off = 0;
            qd0.delete(); qt0.delete(); qd1.delete(); qt1.delete();
            ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
        end else begin
            if (cnt > 0) begin
                for (int t = 0; t < 4; t++) mm[t*TW + off] = 16'h0;
                off++; cnt--;
            end else if (clr) begin
                cnt = TW; off = 0;
            end else begin
                if (r_en) begin
                    qd0.push_back(mm[r_addr]); qt0.push_back(cycn);
                    qd1.push_back(mm[r_addr]); qt1.push_back(cycn + 1);
                end
                if (w_en)
                    for (int b = 0; b < 2; b++)
                        if (w_strb[b]) mm[w_addr][8*b +: 8] = data_in[8*b +: 8];
            end
            ev0 = 0;
            if (qt0.size() > 0 && qt0[0] == cycn) begin
                ev0 = 1; ed0 = qd0.pop_front(); void'(qt0.pop_front());
            end
            ev1 = 0;
            if (qt1.size() > 0 && qt1[0] == cycn) begin
                ev1 = 1; ed1 = qd1.pop_front(); void'(qt1.pop_front());
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("m_busy0", busy0, cnt > 0);
            chk("m_busy1", busy1, cnt > 0);
            chk("m_vld0", r_valid0, ev0);
            chk("m_vld1", r_valid1, ev1);
            chk("m_dout0", data_out0, ed0);
            chk("m_dout1", data_out1, ed1);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic wr(input logic [12:0] a, input logic [15:0] d, input logic [1:0] s);
        w_en = 1; w_addr = a; data_in = d; w_strb = s;
        @(negedge clk);
        w_en = 0;
    endtask

    task automatic rd(input string nm, input logic [12:0] a, input logic [15:0] exp);
        r_en = 1; r_addr = a;
        @(negedge clk);
        r_en = 0;
        chk(nm, data_out0, exp);
        chk({nm, "_v"}, r_valid0, 1);
    endtask

    initial begin
        int bcnt;
        rst = 1; clr = 0; w_en = 0; r_en = 0;
        w_strb = 0; w_addr = 0; r_addr = 0; data_in = 0;
        @(negedge clk);
        started = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy0, 0);  chk("rst_vld0", r_valid0, 0);
        chk("rst_dout0", data_out0, 0); chk("rst_dout1", data_out1, 0);
        rst = 0;

        // basic fill and back-to-back readback
        for (int i = 0; i < 16; i++) wr(13'(i), 16'(i + 32), 2'b11);
        for (int i = 0; i < 16; i++) begin
            r_en = 1; r_addr = 13'(i);
            @(negedge clk);
            chk("seq_rd", data_out0, 16'(i + 32));
            chk("seq_vld", r_valid0, 1);
        end
        r_en = 0;
        @(negedge clk);
        chk("hold_vld", r_valid0, 0);
        chk("hold_dout", data_out0, 16'd47);

        // tile boundary
        wr(13'd2047, 16'hA5A5, 2'b11);
        wr(13'd2048, 16'h5A5A, 2'b11);
        rd("x_2047", 13'd2047, 16'hA5A5);
        rd("x_2048", 13'd2048, 16'h5A5A);
        rd("x_0", 13'd0, 16'd32);

        // byte strobes, including an empty strobe
        wr(13'd5, 16'h1234, 2'b11);
        wr(13'd5, 16'hFFFF, 2'b01);
        wr(13'd5, 16'hEEEE, 2'b00);
        rd("strb", 13'd5, 16'h12FF);

        // same-cycle read and write: old data first
        wr(13'd7, 16'h0003, 2'b11);
        r_en = 1; r_addr = 7; w_en = 1; w_addr = 7; data_in = 16'h0009; w_strb = 2'b11;
        @(negedge clk);
        r_en = 0; w_en = 0;
        chk("rbw_d0", data_out0, 16'h0003);
        chk("rbw_v1_early", r_valid1, 0);
        @(negedge clk);
        chk("rbw_v1", r_valid1, 1);
        chk("rbw_d1", data_out1, 16'h0003);
        rd("rbw_new", 13'd7, 16'h0009);
        @(negedge clk);
        chk("rbw_new1", data_out1, 16'h0009);

        // full clear, with access attempts and a clr retrigger while busy
        wr(13'd0, 16'hDEAD, 2'b11);
        wr(13'd4095, 16'hBEEF, 2'b11);
        wr(13'd8191, 16'hCAFE, 2'b11);
        wr(13'd3, 16'h3333, 2'b11);
        clr = 1; r_en = 1; r_addr = 0; w_en = 1; w_addr = 10; data_in = 16'h1010; w_strb = 2'b11;
        @(negedge clk);
        clr = 0; r_en = 0; w_en = 0;
        chk("clr_prio_vld", r_valid0, 0);
        bcnt = 0;
        while (busy0 && bcnt < 4000) begin
            bcnt++;
            if (bcnt == 10) begin
                w_en = 1; w_addr = 3; data_in = 16'h7777; r_en = 1; r_addr = 4095; clr = 1;
            end else begin
                w_en = 0; r_en = 0; clr = 0;
            end
            @(negedge clk);
        end
        w_en = 0; r_en = 0; clr = 0;
        chk("busy_len", bcnt, TW);
        rd("clr_0", 13'd0, 16'h0);
        rd("clr_4095", 13'd4095, 16'h0);
        rd("clr_8191", 13'd8191, 16'h0);
        rd("clr_drop", 13'd3, 16'h0);

        // reset in the middle of a clear
        wr(13'd99, 16'h1111, 2'b11);
        wr(13'd1000, 16'h2222, 2'b11);
        wr(13'd100, 16'h4444, 2'b11);
        rd("pre_rst", 13'd1000, 16'h2222);
        clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (100) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("mid_busy", busy0, 0);
        chk("mid_vld", r_valid0, 0);
        chk("mid_dout", data_out0, 16'h0);
        chk("mid_dout1", data_out1, 16'h0);
        rd("mid_99", 13'd99, 16'h0);
        rd("mid_1000", 13'd1000, 16'h2222);
        rd("mid_100", 13'd100, 16'h4444);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
